// File: rtl/padding_nd_pkg.sv
// Shared types and config helpers for the spatial padding stage.
package padding_nd_pkg;

    localparam int MAX_PAD     = 8;
    localparam int PKG_MAX_W   = 256;
    localparam int PKG_MAX_H   = 256;
    localparam int PKG_ELEM_W  = 8;
    localparam int SIZE_W_BITS = $clog2(PKG_MAX_W) + 1;
    localparam int SIZE_H_BITS = $clog2(PKG_MAX_H) + 1;
    localparam int PAD_BITS    = $clog2(MAX_PAD) + 1;

    typedef struct packed {
        logic [SIZE_W_BITS-1:0] size_w;
        logic [SIZE_H_BITS-1:0] size_h;
        logic [PAD_BITS-1:0]    pad_top;
        logic [PAD_BITS-1:0]    pad_bottom;
        logic [PAD_BITS-1:0]    pad_left;
        logic [PAD_BITS-1:0]    pad_right;
        logic [PKG_ELEM_W-1:0]  pad_value;
    } PadCfg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BYPASS = 2'd2,
        DRAIN  = 2'd3
    } PadState;

    function automatic logic cfg_illegal(input PadCfg c);
        return (c.size_w == '0) || (c.size_h == '0) ||
               (c.pad_top    > PAD_BITS'(MAX_PAD)) || (c.pad_bottom > PAD_BITS'(MAX_PAD)) ||
               (c.pad_left   > PAD_BITS'(MAX_PAD)) || (c.pad_right  > PAD_BITS'(MAX_PAD));
    endfunction

    function automatic logic cfg_no_pad(input PadCfg c);
        return (c.pad_top == '0) && (c.pad_bottom == '0) &&
               (c.pad_left == '0) && (c.pad_right == '0);
    endfunction

endpackage

// File: rtl/padding_nd_pad_pos_counter.sv
// Row/column walker over the padded tile; position flags are registered
// from next-position values so they are ready at the start of each cycle.
module pad_pos_counter #(
    parameter int DIM_W = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear_i,
    input  logic                  advance_i,
    input  padding_nd_pkg::PadCfg cfg_i,
    output logic                  interior_o,
    output logic                  first_o,
    output logic                  last_w_o,
    output logic                  last_elm_o
);
    import padding_nd_pkg::*;

    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    logic [DIM_W-1:0] pw_q, pw_d, ph_q, ph_d;
    logic [DIM_W-1:0] row_lo_q, row_lo_d, row_hi_q, row_hi_d;
    logic [DIM_W-1:0] col_lo_q, col_lo_d, col_hi_q, col_hi_d;
    logic             interior_q, interior_d, first_q, first_d;
    logic             last_w_q, last_w_d, last_elm_q, last_elm_d;
    logic             unused_pad_value_s;

    assign unused_pad_value_s = ^cfg_i.pad_value;

    // Bounds and padded dimensions: captured from the offered config on clear
    always_comb begin
        row_lo_d = row_lo_q;
        row_hi_d = row_hi_q;
        col_lo_d = col_lo_q;
        col_hi_d = col_hi_q;
        pw_d     = pw_q;
        ph_d     = ph_q;
        if (clear_i) begin
            row_lo_d = DIM_W'(cfg_i.pad_top);
            row_hi_d = DIM_W'(cfg_i.pad_top) + DIM_W'(cfg_i.size_h);
            col_lo_d = DIM_W'(cfg_i.pad_left);
            col_hi_d = DIM_W'(cfg_i.pad_left) + DIM_W'(cfg_i.size_w);
            ph_d     = row_hi_d + DIM_W'(cfg_i.pad_bottom);
            pw_d     = col_hi_d + DIM_W'(cfg_i.pad_right);
        end else begin
            pw_d = pw_q;
            ph_d = ph_q;
        end
    end

    // Position update; the registered last-in-row flag drives the wrap
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (last_w_q) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Flags for the position the counters will hold next cycle
    always_comb begin
        interior_d = (row_d >= row_lo_d) && (row_d < row_hi_d) &&
                     (col_d >= col_lo_d) && (col_d < col_hi_d);
        first_d    = (row_d == '0) && (col_d == '0);
        last_w_d   = (col_d == pw_d - DIM_W'(1));
        last_elm_d = last_w_d && (row_d == ph_d - DIM_W'(1));
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q      <= '0;
            col_q      <= '0;
            pw_q       <= '0;
            ph_q       <= '0;
            row_lo_q   <= '0;
            row_hi_q   <= '0;
            col_lo_q   <= '0;
            col_hi_q   <= '0;
            interior_q <= 1'b0;
            first_q    <= 1'b0;
            last_w_q   <= 1'b0;
            last_elm_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            pw_q       <= pw_d;
            ph_q       <= ph_d;
            row_lo_q   <= row_lo_d;
            row_hi_q   <= row_hi_d;
            col_lo_q   <= col_lo_d;
            col_hi_q   <= col_hi_d;
            interior_q <= interior_d;
            first_q    <= first_d;
            last_w_q   <= last_w_d;
            last_elm_q <= last_elm_d;
        end
    end

    assign interior_o = interior_q;
    assign first_o    = first_q;
    assign last_w_o   = last_w_q;
    assign last_elm_o = last_elm_q;

endmodule

// File: rtl/padding_nd.sv
// Spatial padding of a streamed H x W tile with per-side pad amounts,
// programmable pad constant, bypass and ready/valid on both sides.
module padding_nd #(
    parameter int LANES   = 8,
    parameter int ELEM_W  = 8,
    parameter int MAX_W   = 256,
    parameter int MAX_H   = 256,
    parameter int MAX_PAD = 8,
    parameter int DIM_W   = $clog2(MAX_W + 2*MAX_PAD) + 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(MAX_W):0]    size_w,
    input  logic [$clog2(MAX_H):0]    size_h,
    input  logic [$clog2(MAX_PAD):0]  pad_top,
    input  logic [$clog2(MAX_PAD):0]  pad_bottom,
    input  logic [$clog2(MAX_PAD):0]  pad_left,
    input  logic [$clog2(MAX_PAD):0]  pad_right,
    input  logic [ELEM_W-1:0]         pad_value,
    input  logic [LANES*ELEM_W-1:0]   d_value,
    input  logic                      d_valid,
    output logic                      d_ready,
    output logic [LANES*ELEM_W-1:0]   q_value,
    output logic                      q_valid,
    input  logic                      q_ready,
    output logic                      q_new_tile,
    output logic                      q_last_w,
    output logic                      q_last_elm,
    output logic                      q_is_pad,
    output logic                      cfg_err
);
    import padding_nd_pkg::*;

    PadCfg                    cfg_s;
    PadState                  state_q, state_d;
    logic [LANES*ELEM_W-1:0]  q_value_q, q_value_d;
    logic                     q_valid_q, q_valid_d, q_is_pad_q, q_is_pad_d;
    logic                     q_new_tile_q, q_new_tile_d, q_last_w_q, q_last_w_d;
    logic                     q_last_elm_q, q_last_elm_d, cfg_err_q, cfg_err_d;
    logic [ELEM_W-1:0]        pad_value_q, pad_value_d;
    logic                     adv_s, load_s, load_pad_s, d_ready_s, cnt_clear_s;
    logic                     interior_s, first_s, last_w_s, last_elm_s;

    assign cfg_s = '{size_w: size_w, size_h: size_h, pad_top: pad_top,
                     pad_bottom: pad_bottom, pad_left: pad_left,
                     pad_right: pad_right, pad_value: pad_value};

    assign adv_s = !q_valid_q || q_ready;

    pad_pos_counter #(.DIM_W(DIM_W)) u_pos (
        .clk        (clk),
        .resetn     (resetn),
        .clear_i    (cnt_clear_s),
        .advance_i  (load_s),
        .cfg_i      (cfg_s),
        .interior_o (interior_s),
        .first_o    (first_s),
        .last_w_o   (last_w_s),
        .last_elm_o (last_elm_s)
    );

    // FSM next state, input handshake and output-register load selection
    always_comb begin
        state_d      = state_q;
        q_valid_d    = q_valid_q;
        q_value_d    = q_value_q;
        q_is_pad_d   = q_is_pad_q;
        q_new_tile_d = q_new_tile_q;
        q_last_w_d   = q_last_w_q;
        q_last_elm_d = q_last_elm_q;
        pad_value_d  = pad_value_q;
        cfg_err_d    = 1'b0;
        cnt_clear_s  = 1'b0;
        load_s       = 1'b0;
        load_pad_s   = 1'b0;
        d_ready_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_illegal(cfg_s)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cnt_clear_s = 1'b1;
                        pad_value_d = cfg_s.pad_value;
                        state_d     = cfg_no_pad(cfg_s) ? BYPASS : RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (adv_s) begin
                    q_valid_d = 1'b0;
                    if (interior_s) begin
                        d_ready_s = 1'b1;
                        load_s    = d_valid;
                    end else begin
                        load_s     = 1'b1;
                        load_pad_s = 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            BYPASS: begin
                if (adv_s) begin
                    q_valid_d = 1'b0;
                    d_ready_s = 1'b1;
                    load_s    = d_valid;
                end else begin
                    load_s = 1'b0;
                end
            end
            DRAIN: begin
                if (adv_s) begin
                    q_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_s) begin
            q_valid_d    = 1'b1;
            q_value_d    = load_pad_s ? {LANES{pad_value_q}} : d_value;
            q_is_pad_d   = load_pad_s;
            q_new_tile_d = first_s;
            q_last_w_d   = last_w_s;
            q_last_elm_d = last_elm_s;
            state_d      = last_elm_s ? DRAIN : state_q;
        end else begin
            cnt_clear_s = cnt_clear_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            q_valid_q    <= 1'b0;
            q_value_q    <= '0;
            q_is_pad_q   <= 1'b0;
            q_new_tile_q <= 1'b0;
            q_last_w_q   <= 1'b0;
            q_last_elm_q <= 1'b0;
            pad_value_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_valid_q    <= q_valid_d;
            q_value_q    <= q_value_d;
            q_is_pad_q   <= q_is_pad_d;
            q_new_tile_q <= q_new_tile_d;
            q_last_w_q   <= q_last_w_d;
            q_last_elm_q <= q_last_elm_d;
            pad_value_q  <= pad_value_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_ready  = (state_q == IDLE);
    assign d_ready    = d_ready_s;
    assign q_value    = q_value_q;
    assign q_valid    = q_valid_q;
    assign q_is_pad   = q_is_pad_q;
    assign q_new_tile = q_new_tile_q;
    assign q_last_w   = q_last_w_q;
    assign q_last_elm = q_last_elm_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_padding_nd.sv
// Randomised bench for padding_nd with a row/column reference model.
module tb_padding_nd;
    localparam int DW = 64;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          cfg_valid = 1'b0, cfg_ready;
    logic [8:0]    size_w = '0, size_h = '0;
    logic [3:0]    pad_top = '0, pad_bottom = '0, pad_left = '0, pad_right = '0;
    logic [7:0]    pad_value = '0;
    logic [DW-1:0] d_value = '0, q_value;
    logic          d_valid = 1'b0, d_ready, q_valid, q_ready = 1'b1;
    logic          q_new_tile, q_last_w, q_last_elm, q_is_pad, cfg_err;

    padding_nd dut (
        .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .size_w(size_w), .size_h(size_h), .pad_top(pad_top), .pad_bottom(pad_bottom),
        .pad_left(pad_left), .pad_right(pad_right), .pad_value(pad_value),
        .d_value(d_value), .d_valid(d_valid), .d_ready(d_ready),
        .q_value(q_value), .q_valid(q_valid), .q_ready(q_ready),
        .q_new_tile(q_new_tile), .q_last_w(q_last_w), .q_last_elm(q_last_elm),
        .q_is_pad(q_is_pad), .cfg_err(cfg_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] value;
        logic          is_pad;
        logic          new_tile;
        logic          last_w;
        logic          last_elm;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] din[$];
    int            n_checks = 0, n_errors = 0;
    int            beats, lastw_cnt, laste_cnt, pad_cnt;
    bit            mon_en = 1'b0, tile_done = 1'b0;
    int            g_sw, g_sh, g_t, g_b, g_l, g_r;
    logic [7:0]    g_pv;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the padded grid, pulling input beats in order for interior cells
    task automatic prep(input int sw, sh, t, b, l, r, input logic [7:0] pv, input int seq);
        int pw, ph, k;
        beat_t e;
        g_sw = sw; g_sh = sh; g_t = t; g_b = b; g_l = l; g_r = r; g_pv = pv;
        din.delete();
        exp_q.delete();
        for (int i = 0; i < sw*sh; i++)
            din.push_back(seq > 0 ? DW'(seq + i) : {$urandom, $urandom});
        pw = sw + l + r;
        ph = sh + t + b;
        k  = 0;
        for (int rr = 0; rr < ph; rr++) begin
            for (int cc = 0; cc < pw; cc++) begin
                e.is_pad   = !(rr >= t && rr < t + sh && cc >= l && cc < l + sw);
                e.value    = e.is_pad ? {8{pv}} : din[k];
                k          = e.is_pad ? k : k + 1;
                e.new_tile = (rr == 0 && cc == 0);
                e.last_w   = (cc == pw - 1);
                e.last_elm = (rr == ph - 1 && cc == pw - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process: hold-while-stalled, one-cycle latency, beat vs model, cfg_ready after last beat
    initial begin
        beat_t held, got, e;
        bit stall_prev, prev_acc, cfg_next;
        logic [DW-1:0] prev_d;
        stall_prev = 1'b0; prev_acc = 1'b0; cfg_next = 1'b0; held = '0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (!resetn || !mon_en) begin
                stall_prev = 1'b0; prev_acc = 1'b0; cfg_next = 1'b0;
            end else begin
                got = {q_value, q_is_pad, q_new_tile, q_last_w, q_last_elm};
                if (cfg_next) begin
                    check("cfg_ready_after_last", 128'(cfg_ready), 128'(1));
                    cfg_next = 1'b0;
                end
                if (stall_prev) check("stall_hold", 128'({q_valid, got}), 128'({1'b1, held}));
                if (prev_acc) check("latency", 128'({q_valid, q_value}), 128'({1'b1, prev_d}));
                if (q_valid && q_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL extra_beat: got %h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 128'(got), 128'(e));
                        beats++;
                        lastw_cnt += int'(q_last_w);
                        laste_cnt += int'(q_last_elm);
                        pad_cnt   += int'(q_is_pad);
                        if (q_last_elm) begin
                            tile_done = 1'b1;
                            cfg_next  = 1'b1;
                        end
                    end
                end
                stall_prev = q_valid && !q_ready;
                held       = got;
                prev_acc   = d_valid && d_ready;
                prev_d     = d_value;
            end
        end
    end

    task automatic run(input int qmode, input int dmode, input int abort_after);
        int idx, cyc;
        bit acc;
        idx = 0; cyc = 0;
        beats = 0; lastw_cnt = 0; laste_cnt = 0; pad_cnt = 0; tile_done = 1'b0;
        @(posedge clk); #1;
        size_w = 9'(g_sw); size_h = 9'(g_sh);
        pad_top = 4'(g_t); pad_bottom = 4'(g_b); pad_left = 4'(g_l); pad_right = 4'(g_r);
        pad_value = g_pv; cfg_valid = 1'b1;
        @(negedge clk);
        check("cfg_ready_idle", 128'(cfg_ready), 128'(1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        mon_en = 1'b1;
        while (!tile_done && cyc < 3000) begin
            d_value = (idx < din.size()) ? din[idx] : {$urandom, $urandom};
            d_valid = (dmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (qmode)
                0:       q_ready = 1'b1;
                1:       q_ready = (cyc % 2 == 0);
                default: q_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            acc = d_valid && d_ready;
            if (acc && idx >= din.size()) begin
                n_checks++; n_errors++;
                $display("FAIL extra_input: got consumed beat %0d expected only %0d", idx, din.size());
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (abort_after > 0 && beats >= abort_after) break;
        end
        d_valid = 1'b0;
        q_ready = 1'b1;
        if (abort_after == 0) begin
            if (!tile_done) begin
                n_checks++; n_errors++;
                $display("FAIL tile_timeout: got %0d beats expected %0d", beats, beats + exp_q.size());
            end
            @(negedge clk);
            @(posedge clk); #1;
            mon_en = 1'b0;
            check("model_drained", 128'(exp_q.size()), 128'(0));
        end
    endtask

    task automatic check_idle(input string name);
        check(name, 128'({q_valid, q_new_tile, q_last_w, q_last_elm, q_is_pad, cfg_err, d_ready, cfg_ready}),
              128'(8'b0000_0001));
        check({name, "_qval"}, 128'(q_value), 128'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        // 2x2 with one pad on every side
        prep(2, 2, 1, 1, 1, 1, 8'h7F, 1);
        check("m_len16", 128'(exp_q.size()), 128'(16));
        check("m_first", 128'(exp_q[0]), 128'({64'h7F7F_7F7F_7F7F_7F7F, 4'b1100}));
        check("m_int1", 128'(exp_q[5].value), 128'(64'd1));
        check("m_int4", 128'(exp_q[10].value), 128'(64'd4));
        check("m_last", 128'(exp_q[15]), 128'({64'h7F7F_7F7F_7F7F_7F7F, 4'b1011}));
        run(0, 0, 0);
        check("t1_beats", 128'(beats), 128'(16));
        check("t1_lastw", 128'(lastw_cnt), 128'(4));
        check("t1_laste", 128'(laste_cnt), 128'(1));
        check("t1_pads", 128'(pad_cnt), 128'(12));

        // Asymmetric 3x1, PW=5 PH=3
        prep(3, 1, 0, 2, 2, 0, 8'hA5, 10);
        check("m_asym_len", 128'(exp_q.size()), 128'(15));
        check("m_asym_d0", 128'(exp_q[2]), 128'({64'd10, 4'b0000}));
        check("m_asym_d2", 128'(exp_q[4]), 128'({64'd12, 4'b0010}));
        check("m_asym_pad", 128'(exp_q[5].is_pad), 128'(1));
        run(0, 0, 0);
        check("asym_beats", 128'(beats), 128'(15));
        check("asym_lastw", 128'(lastw_cnt), 128'(3));

        // Bypass 4x4
        prep(4, 4, 0, 0, 0, 0, 8'h00, 0);
        run(0, 0, 0);
        check("byp_beats", 128'(beats), 128'(16));
        check("byp_pads", 128'(pad_cnt), 128'(0));

        // Backpressure: q_ready 1010..., random d_valid
        prep(2, 2, 1, 1, 1, 1, 8'h7F, 1);
        run(1, 1, 0);
        check("bp_beats", 128'(beats), 128'(16));

        // Illegal configs: zero width, oversized pad
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            size_w = (i == 0) ? 9'd0 : 9'd2; size_h = 9'd2;
            pad_top = 4'd0; pad_bottom = 4'd0; pad_right = 4'd0;
            pad_left = (i == 0) ? 4'd1 : 4'd9;
            cfg_valid = 1'b1;
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            @(negedge clk);
            check("illegal_err", 128'({cfg_err, cfg_ready, q_valid}), 128'(3'b110));
            @(negedge clk);
            check("illegal_pulse", 128'({cfg_err, cfg_ready, q_valid}), 128'(3'b010));
        end

        // Degenerate shapes
        prep(1, 1, 0, 0, 0, 0, 8'h00, 0);
        check("m_1x1_tags", 128'(exp_q[0][3:0]), 128'(4'b0111));
        run(2, 1, 0);
        check("deg_1x1_laste", 128'(laste_cnt), 128'(1));
        prep(1, 3, 1, 1, 0, 0, 8'h5A, 0);
        run(2, 1, 0);
        check("deg_pw1_lastw", 128'(lastw_cnt), 128'(5));

        // Reset after 5 beats, then a fresh tile
        prep(2, 2, 1, 1, 1, 1, 8'h3C, 0);
        run(0, 0, 5);
        mon_en = 1'b0;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check_idle("mid_reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        prep(2, 2, 1, 1, 1, 1, 8'h11, 0);
        run(2, 1, 0);
        check("post_reset_beats", 128'(beats), 128'(16));

        // Random tiles
        for (int n = 0; n < 8; n++) begin
            int t, b, l, r;
            t = $urandom_range(0, 2); b = $urandom_range(0, 2);
            l = $urandom_range(0, 2); r = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) begin t = 0; b = 0; l = 0; r = 0; end
            prep($urandom_range(1, 5), $urandom_range(1, 4), t, b, l, r, 8'($urandom), 0);
            run(2, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
